fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Controls the program counter register and the instruction-memory fetch port of the RISC-V core.
- Issues fetch requests at the current PC and advances the PC by PC_STEP on each issue.
- Applies branch/jump redirects and trap entries, and discards stale fetch responses.
- Presents fetched instructions to decode through a one-entry valid/ready output register.

Parameters:
PC_STEP, 32'd4, increment applied to the PC on every fetch issue
NOP_INSTR, 32'h00000013, value driven on instr while instr_valid=0

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  reset; synchronous, active-high
pc_value  input  32  current PC from the PC register
pc_nwen  output  1  PC register write enable, active-low
new_pc_value  output  32  value written to the PC register when pc_nwen=0
imem_req  output  1  single-cycle fetch request; memory always accepts it
imem_addr  output  32  fetch address, valid when imem_req=1
imem_ack  input  1  response strobe; exactly one per request, at least 1 cycle after the request
imem_rdata  input  32  instruction word, valid with imem_ack
instr_valid  output  1  output register holds a valid instruction
instr  output  32  fetched instruction
instr_pc  output  32  address of instr
instr_ready  input  1  decode accepts instr this cycle
redirect_valid  input  1  branch/jump taken pulse
redirect_target  input  32  redirect address
trap_valid  input  1  trap entry pulse; has priority over redirect_valid
trap_vector  input  32  trap handler address

Behaviour:
- Reset (rst=1 at clk edge): state=IDLE, instr_valid=0, instr=NOP_INSTR, instr_pc=0, pending_pc=0.
- While rst=1: pc_nwen=1, imem_req=0. Reset of the PC itself belongs to the PC register.
- pc_nwen, new_pc_value, imem_req and imem_addr are combinational from state and inputs.
- Events per cycle: redirect event = trap_valid | redirect_valid; tgt = trap_valid ? trap_vector : redirect_target.
- IDLE, redirect event:
  - pc_nwen=0, new_pc_value=tgt; no request issued.
  - instr_valid cleared next cycle.
  - Stay in IDLE.
- IDLE, no event, and (instr_valid=0 or instr_ready=1):
  - Issue: imem_req=1, imem_addr=pc_value, pc_nwen=0, new_pc_value=pc_value+PC_STEP (mod 2^32, wraps 0xFFFFFFFC->0x00000000).
  - pending_pc<=pc_value; go to WAIT.
- IDLE, otherwise: hold. pc_nwen=1, imem_req=0.
- WAIT, imem_ack=1 and no event: instr<=imem_rdata, instr_pc<=pending_pc, instr_valid<=1; go to IDLE.
- WAIT, event with imem_ack=1: load tgt into PC, drop rdata, instr_valid<=0; go to IDLE.
- WAIT, event without imem_ack: load tgt into PC, instr_valid<=0; go to DISCARD.
- DISCARD:
  - Event: load the new tgt into PC and stay in DISCARD.
  - imem_ack=1: drop rdata; go to IDLE. An event in the same cycle still loads the PC.
- Output register consumption: instr_valid=1 and instr_ready=1 with no load in the same cycle clears instr_valid next cycle.
- When instr_valid=0, instr is driven as NOP_INSTR.
- At most one request outstanding. Minimum fetch period is 2 cycles.
- pc_nwen=0 in any cycle with a redirect event, regardless of state.

Optional Feature:
- Macro FETCH_MISALIGN_CHECK_EN, adds output fetch_misaligned (1 bit, reset 0).
- Defined:
  - redirect_valid with redirect_target[1:0]!=2'b00 and trap_valid=0 is not applied: PC unchanged, state unchanged, no flush.
  - fetch_misaligned pulses 1 cycle later for one cycle.
- Not defined: no port; redirect_target loaded with bits[1:0] forced to 2'b00.
- trap_vector is never checked.

Decomposition:
- Shared package fetch_pkg:
  - State encoding IDLE=2'd0, WAIT=2'd1, DISCARD=2'd2.
  - PC_STEP and NOP_INSTR defaults.
- Sub-module fetch_out_reg: one-entry valid/ready instruction register with load, flush and consume inputs.

Test Plan:
- Reset then pc_value=0x0, 1-cycle ack latency, instr_ready=1:
  - imem_req at cycle 1 with addr 0x0 and new_pc_value 0x4.
  - instr_valid with instr_pc 0x0 two cycles later.
  - Next request at 0x4.
- instr_ready=0 with instr_valid=1: no imem_req and pc_nwen=1 until instr_ready=1; instr held stable.
- redirect_valid target 0x100 while in WAIT, ack 2 cycles later:
  - PC loaded 0x100; acked rdata discarded, instr_valid=0.
  - Next request at 0x100.
- trap_valid vector 0x80 and redirect_valid target 0x200 in the same cycle: new_pc_value=0x80.
- pc_value=0xFFFFFFFC issue: new_pc_value=0x00000000.
- With FETCH_MISALIGN_CHECK_EN, redirect target 0x102: PC unchanged, fetch_misaligned pulses once. Without the macro, PC loaded 0x100.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared state encoding, defaults and helpers for the instruction fetch sequencer.
// No logic of its own; imported by fetch_out_reg and fetch_sequencer.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

  localparam logic [31:0] PC_STEP_DEFAULT   = 32'd4;
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

  // Forces a byte address onto a 32-bit instruction boundary.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & ~32'd3;
  endfunction

endpackage

// File: rtl/fetch_out_reg.sv
// One-entry instruction output register: load/flush/consume take effect on the next edge.
// Backpressure: holds the entry while consume (decode ready) is low; flush beats load beats consume.
module fetch_out_reg
  import fetch_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] load_instr,
  input  logic [31:0] load_pc,
  input  logic        flush,
  input  logic        consume,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
);

  logic        valid_q;
  logic [31:0] instr_q;
  logic [31:0] pc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
      pc_q    <= 32'd0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (load) begin
      valid_q <= 1'b1;
      instr_q <= load_instr;
      pc_q    <= load_pc;
    end else if (valid_q && consume) begin
      valid_q <= 1'b0;
    end
  end

  assign instr_valid = valid_q;
  assign instr       = valid_q ? instr_q : NOP_INSTR;
  assign instr_pc    = pc_q;

endmodule

// File: rtl/fetch_sequencer.sv
// PC/fetch control: issues one imem request at a time (min period 2 cycles), redirects/traps flush stale data.
// Stalls issue while the output register is full and decode not ready; FETCH_MISALIGN_CHECK_EN rejects misaligned redirects.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [31:0] PC_STEP   = PC_STEP_DEFAULT,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_value,
  output logic        pc_nwen,
  output logic [31:0] new_pc_value,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        trap_valid,
  input  logic [31:0] trap_vector
`ifdef FETCH_MISALIGN_CHECK_EN
  ,
  output logic        fetch_misaligned
`endif
);

  fetch_state_t state;
  fetch_state_t state_nxt;
  logic [31:0]  pending_pc;
  logic         redirect_ok;
  logic         evt;
  logic [31:0]  tgt;
  logic         issue;
  logic         load;
  logic         flush;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic misaligned;

  // A misaligned branch target is dropped entirely; a trap in the same cycle still wins.
  assign misaligned  = redirect_valid & ~trap_valid & (redirect_target[1:0] != 2'b00);
  assign redirect_ok = redirect_valid & ~misaligned;
  assign tgt         = trap_valid ? trap_vector : redirect_target;

  always_ff @(posedge clk) begin
    if (rst) fetch_misaligned <= 1'b0;
    else     fetch_misaligned <= misaligned;
  end
`else
  assign redirect_ok = redirect_valid;
  assign tgt         = trap_valid ? trap_vector : align_word(redirect_target);
`endif

  assign evt = trap_valid | redirect_ok;

  always_comb begin
    state_nxt    = state;
    pc_nwen      = 1'b1;
    new_pc_value = pc_value;
    imem_req     = 1'b0;
    imem_addr    = pc_value;
    issue        = 1'b0;
    load         = 1'b0;
    flush        = 1'b0;

    if (evt) begin
      pc_nwen      = 1'b0;
      new_pc_value = tgt;
      flush        = 1'b1;
    end

    case (state)
      IDLE: begin
        if (!evt && (!instr_valid || instr_ready)) begin
          issue        = 1'b1;
          imem_req     = 1'b1;
          pc_nwen      = 1'b0;
          new_pc_value = pc_value + PC_STEP;
          state_nxt    = WAIT;
        end
      end
      WAIT: begin
        if (imem_ack) begin
          load      = ~evt;
          state_nxt = IDLE;
        end else if (evt) begin
          state_nxt = DISCARD;
        end
      end
      DISCARD: begin
        if (imem_ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    if (rst) begin
      pc_nwen  = 1'b1;
      imem_req = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pending_pc <= 32'd0;
    end else begin
      state <= state_nxt;
      if (issue) pending_pc <= pc_value;
    end
  end

  fetch_out_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_out_reg (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .load_instr  (imem_rdata),
    .load_pc     (pending_pc),
    .flush       (flush),
    .consume     (instr_ready),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc)
  );

endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomized bench for fetch_sequencer against a flag-based transaction model with a built-in PC register and imem.
// Directed prologue follows the main scenarios (stall, redirect in flight, trap priority, wrap, misaligned target).
module tb_fetch_sequencer;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_value;
  logic        pc_nwen;
  logic [31:0] new_pc_value;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        trap_valid;
  logic [31:0] trap_vector;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic        fetch_misaligned;
`endif

  fetch_sequencer dut (
    .clk             (clk),
    .rst             (rst),
    .pc_value        (pc_value),
    .pc_nwen         (pc_nwen),
    .new_pc_value    (new_pc_value),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .imem_rdata      (imem_rdata),
    .instr_valid     (instr_valid),
    .instr           (instr),
    .instr_pc        (instr_pc),
    .instr_ready     (instr_ready),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .trap_valid      (trap_valid),
    .trap_vector     (trap_vector)
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    .fetch_misaligned(fetch_misaligned)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model: PC register contents, one outstanding request (maybe stale), and the decode-facing entry.
  logic [31:0] m_pc      = 32'd0;
  logic        m_out     = 1'b0;
  logic        m_stale   = 1'b0;
  int          m_cnt     = 0;
  logic [31:0] m_rsp     = 32'd0;
  logic [31:0] m_pend    = 32'd0;
  logic        m_v       = 1'b0;
  logic [31:0] m_instr   = NOP;
  logic [31:0] m_ipc     = 32'd0;
  logic        m_mis     = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return (addr * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  // Called just after a rising edge; drives one cycle of inputs, checks at the falling edge.
  task automatic run_cycle(input logic rv, input logic [31:0] rt, input logic tv,
                           input logic [31:0] tvec, input logic rdy, input int lat);
    logic        mis, ev, iss, ack;
    logic [31:0] tgt;
    ack             = m_out && (m_cnt == 1);
    pc_value        = m_pc;
    imem_ack        = ack;
    imem_rdata      = ack ? m_rsp : $urandom;
    redirect_valid  = rv;
    redirect_target = rt;
    trap_valid      = tv;
    trap_vector     = tvec;
    instr_ready     = rdy;
    @(negedge clk);

`ifdef FETCH_MISALIGN_CHECK_EN
    mis = rv && !tv && (rt[1:0] != 2'b00);
    check_val("fetch_misaligned", 32'(fetch_misaligned), 32'(m_mis));
`else
    mis = 1'b0;
`endif
    ev  = tv || (rv && !mis);
    tgt = tv ? tvec : (rt & ~32'd3);
    iss = !m_out && !ev && (!m_v || rdy);

    check_val("pc_nwen", 32'(pc_nwen), 32'(!(ev || iss)));
    if (ev || iss) check_val("new_pc_value", new_pc_value, ev ? tgt : m_pc + 32'd4);
    check_val("imem_req", 32'(imem_req), 32'(iss));
    if (iss) check_val("imem_addr", imem_addr, m_pc);
    check_val("instr_valid", 32'(instr_valid), 32'(m_v));
    check_val("instr", instr, m_v ? m_instr : NOP);
    if (m_v) check_val("instr_pc", instr_pc, m_ipc);

    if (ev) m_v = 1'b0;
    else if (ack && !m_stale) begin
      m_v     = 1'b1;
      m_instr = m_rsp;
      m_ipc   = m_pend;
    end else if (m_v && rdy) m_v = 1'b0;

    if (ack) begin
      m_out   = 1'b0;
      m_stale = 1'b0;
    end else if (m_out) begin
      m_cnt--;
      if (ev) m_stale = 1'b1;
    end
    if (iss) begin
      m_out   = 1'b1;
      m_stale = 1'b0;
      m_cnt   = lat;
      m_rsp   = mem_word(m_pc);
      m_pend  = m_pc;
    end
    m_pc  = ev ? tgt : (iss ? m_pc + 32'd4 : m_pc);
    m_mis = mis;

    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n, input logic rdy, input int lat);
    for (int i = 0; i < n; i++) run_cycle(1'b0, 32'd0, 1'b0, 32'd0, rdy, lat);
  endtask

  initial begin
    rst             = 1'b1;
    pc_value        = 32'd0;
    imem_ack        = 1'b0;
    imem_rdata      = 32'd0;
    instr_ready     = 1'b1;
    redirect_valid  = 1'b1;
    redirect_target = 32'h40;
    trap_valid      = 1'b0;
    trap_vector     = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rst_pc_nwen", 32'(pc_nwen), 32'd1);
    check_val("rst_imem_req", 32'(imem_req), 32'd0);
    check_val("rst_instr_valid", 32'(instr_valid), 32'd0);
    check_val("rst_instr", instr, NOP);
    check_val("rst_instr_pc", instr_pc, 32'd0);
`ifdef FETCH_MISALIGN_CHECK_EN
    check_val("rst_fetch_misaligned", 32'(fetch_misaligned), 32'd0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Basic streaming from PC 0 with one-cycle ack latency.
    idle_cycles(5, 1'b1, 1);
    // Decode stalls: entry held, no further issue.
    idle_cycles(5, 1'b0, 1);
    idle_cycles(3, 1'b1, 1);
    // Redirect while a two-cycle fetch is in flight.
    for (int i = 0; i < 10 && !(m_out && m_cnt > 1); i++) run_cycle(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 2);
    run_cycle(1'b1, 32'h100, 1'b0, 32'd0, 1'b1, 2);
    idle_cycles(6, 1'b1, 1);
    // Trap wins over a simultaneous redirect.
    run_cycle(1'b1, 32'h200, 1'b1, 32'h80, 1'b1, 1);
    idle_cycles(4, 1'b1, 1);
    // PC wrap at the top of the address space.
    run_cycle(1'b1, 32'hFFFF_FFFC, 1'b0, 32'd0, 1'b1, 1);
    idle_cycles(6, 1'b1, 1);
    // Misaligned redirect target.
    for (int i = 0; i < 10 && m_out; i++) run_cycle(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1);
    run_cycle(1'b1, 32'h102, 1'b0, 32'd0, 1'b1, 1);
    idle_cycles(4, 1'b1, 1);

    for (int i = 0; i < 3000; i++) begin
      logic [31:0] rt;
      rt = $urandom;
      if ($urandom_range(0, 3) != 0) rt[1:0] = 2'b00;
      run_cycle($urandom_range(0, 7) == 0, rt, $urandom_range(0, 15) == 0, $urandom,
                $urandom_range(0, 3) != 0, int'($urandom_range(1, 4)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

endmodule
